// File: rtl/upsample_nn.sv
// upsample_nn: 2x upsampler; each input row is buffered while emitted, then replayed.
// Optional: define UPSAMPLE_ZERO_FILL_EN for unpool zero-insertion (top-left copy only).
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif
`ifndef ADDR_FIFO
`define ADDR_FIFO 9
`endif

module upsample_nn #(
  parameter int DATA_W  = `WID_PE_BITS,
  parameter int MAX_ROW = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [`ADDR_FIFO-1:0] row_length,
  input  logic [`ADDR_FIFO-1:0] num_rows,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done
);
  localparam int AF = `ADDR_FIFO;
  localparam int AW = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
  localparam logic [AF-1:0] ONE = AF'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REPLAY, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [AF-1:0]      r_col, w_col_nx;
  logic [AF-1:0]      r_row, w_row_nx;
  logic [AF-1:0]      r_len, w_len_nx;
  logic [AF-1:0]      r_rows, w_rows_nx;
  logic               r_phase, w_phase_nx;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               w_load;
  logic [DATA_W-1:0]  w_ld_data;
  logic [DATA_W-1:0]  w_copy;
  logic [AF-1:0]      w_len_clamp;
  logic               w_slot_free, w_in_hs, w_last_col, w_last_row;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_in_hs     = in_ready && in_valid;
  assign w_last_col  = (r_col == r_len - ONE);
  assign w_last_row  = (r_row == r_rows - ONE);
  // Wide compare so MAX_ROW == 2^AF cannot wrap to zero.
  assign w_len_clamp = ({1'b0, row_length} > (AF+1)'(MAX_ROW)) ? AF'(MAX_ROW) : row_length;

`ifdef UPSAMPLE_ZERO_FILL_EN
  assign w_copy = '0;
`else
  logic [DATA_W-1:0] r_buf [MAX_ROW];
  logic [AW-1:0]     w_idx;
  assign w_idx  = r_col[AW-1:0];
  assign w_copy = r_buf[w_idx];

  // No reset: contents are always written before being read within a frame.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[w_idx] <= in_data;
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_len_nx   = r_len;
    w_rows_nx  = r_rows;
    w_phase_nx = r_phase;
    w_load     = 1'b0;
    w_ld_data  = w_copy;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nx   = w_len_clamp;
          w_rows_nx  = num_rows;
          w_col_nx   = '0;
          w_row_nx   = '0;
          w_phase_nx = 1'b0;
          w_state_nx = (w_len_clamp == '0 || num_rows == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        busy     = 1'b1;
        in_ready = !r_phase && w_slot_free;
        if (!r_phase) begin
          if (in_valid && w_slot_free) begin
            w_load     = 1'b1;
            w_ld_data  = in_data;
            w_phase_nx = 1'b1;
          end
        end else if (w_slot_free) begin
          w_load     = 1'b1;
          w_phase_nx = 1'b0;
          if (w_last_col) begin
            w_col_nx   = '0;
            w_state_nx = S_REPLAY;
          end else begin
            w_col_nx = r_col + ONE;
          end
        end
      end
      S_REPLAY: begin
        busy = 1'b1;
        if (w_slot_free) begin
          w_load     = 1'b1;
          w_phase_nx = !r_phase;
          if (r_phase) begin
            if (w_last_col) begin
              w_col_nx = '0;
              if (w_last_row) begin
                w_state_nx = S_DONE;
              end else begin
                w_row_nx   = r_row + ONE;
                w_state_nx = S_FILL;
              end
            end else begin
              w_col_nx = r_col + ONE;
            end
          end
        end
      end
      S_DONE: begin
        // Stay busy until the last pixel drains so busy drops with the done pulse.
        busy = r_out_valid;
        if (!r_out_valid) begin
          done       = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_len   <= '0;
      r_rows  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_row   <= w_row_nx;
      r_len   <= w_len_nx;
      r_rows  <= w_rows_nx;
      r_phase <= w_phase_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ld_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
